tdc_top: RTL and testbench

Coarse-counter time-to-digital converter for the Artix-7 board. It timestamps the rising edge and measures the width of each pulse on a differential hit input. Each measurement is stored as a record in an internal FIFO. The records are streamed to a host over a UART. The block is the board-level top: it takes the differential system clock, the hit LVDS pair, the push-buttons and switches, and drives the error LEDs and UART pins.

---
 rtl/tdc_top.sv | 231 +++++++++++++++++++++++
 tb/tb_tdc_top.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_top.sv
// tdc_top: coarse-counter TDC. It timestamps each hit pulse, queues the records in a FIFO and streams them over 8N1 UART.
// Define UART_FLOW_CTRL_EN to start each byte only when CTS is low and to drive RTS from the FIFO/readout state.
module tdc_top #(
   parameter int unsigned CLKS_PER_BIT = 1736,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic clk_p,
   input  logic clk_n,
   input  logic irst,
   input  logic hit_p,
   input  logic hit_n,
   input  logic but_rst_read,
   input  logic startWriting,
   input  logic startReading,
   output logic led_WriteERR,
   output logic led_ReadERR,
   input  logic RX,
   output logic TX,
   input  logic CTS,
   output logic RTS
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned RecW  = 48;

   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

   logic clk, hit;
   // Behavioural stand-in for the differential input buffers.
   assign clk = clk_p & ~clk_n;
   assign hit = hit_p & ~hit_n;

   logic unused_rx;
   assign unused_rx = RX;

   logic cts_ok;
   logic empty, full;
`ifdef UART_FLOW_CTRL_EN
   assign cts_ok = ~CTS;
   assign RTS    = empty | ~startReading;
`else
   logic unused_cts;
   assign unused_cts = CTS;
   assign cts_ok     = 1'b1;
   assign RTS        = 1'b0;
`endif

   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk or negedge irst) begin
      if (!irst) cnt_q <= '0;
      else       cnt_q <= cnt_q + CNT_W'(1);
   end

   // Hit path: two synchronizer flops, one history flop, then registered edge pulses.
   logic [2:0]       hit_sync_q;
   logic             rise_q, fall_q, open_q, push_q;
   logic [CNT_W-1:0] rise_ts_q, width;
   logic [15:0]      width_sat;
   logic [RecW-1:0]  rec_in_q;

   assign width     = cnt_q - rise_ts_q;
   assign width_sat = (width > CNT_W'(16'hFFFF)) ? 16'hFFFF : width[15:0];

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         hit_sync_q <= '0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         open_q     <= 1'b0;
         push_q     <= 1'b0;
         rise_ts_q  <= '0;
         rec_in_q   <= '0;
      end else begin
         hit_sync_q <= {hit_sync_q[1:0], hit};
         rise_q     <= hit_sync_q[1] & ~hit_sync_q[2];
         fall_q     <= ~hit_sync_q[1] & hit_sync_q[2];
         push_q     <= 1'b0;
         if (rise_q && startWriting) begin
            rise_ts_q <= cnt_q;
            open_q    <= 1'b1;
         end else if (fall_q && open_q) begin
            open_q   <= 1'b0;
            push_q   <= 1'b1;
            rec_in_q <= {rise_ts_q[31:0], width_sat};
         end
      end
   end

   logic [RecW-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            do_push, pop, do_pop;
   logic [RecW-1:0] fifo_rdata;

   assign full       = count_q == (PtrW+1)'(FIFO_DEPTH);
   assign empty      = count_q == '0;
   assign do_push    = push_q & ~full;
   assign do_pop     = pop & ~empty;
   assign fifo_rdata = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= rec_in_q;
   end

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (PtrW+1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (PtrW+1)'(1);
      end
   end

   logic start_rd_q, wr_err_q, rd_err_q;
   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         start_rd_q <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         start_rd_q <= startReading;
         if (but_rst_read) begin
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
         end else begin
            if (push_q && full) wr_err_q <= 1'b1;
            if (startReading && !start_rd_q && empty) rd_err_q <= 1'b1;
         end
      end
   end
   assign led_WriteERR = wr_err_q;
   assign led_ReadERR  = rd_err_q;

   // Readout: frame_q is a 10-bit shift register whose LSB is the line, so TX comes straight
   // from a flop; byte_q counts bytes started within the record.
   state_e           state_q, state_d;
   logic [RecW-1:0]  rec_q, rec_d;
   logic [9:0]       frame_q, frame_d;
   logic [3:0]       bit_q, bit_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       byte_q, byte_d;
   logic             busy_q, busy_d, abort_q, abort_d;
   logic             tick, abort, start_byte;

   assign tick  = busy_q && (baud_q == BaudW'(CLKS_PER_BIT - 1));
   assign abort = abort_q | but_rst_read;
   assign TX    = frame_q[0];

   always_comb begin
      state_d    = state_q;
      rec_d      = rec_q;
      frame_d    = frame_q;
      bit_d      = bit_q;
      baud_d     = baud_q;
      byte_d     = byte_q;
      busy_d     = busy_q;
      abort_d    = abort;
      pop        = 1'b0;
      start_byte = 1'b0;
      if (busy_q) begin
         baud_d = baud_q + BaudW'(1);
         if (tick) begin
            baud_d  = '0;
            frame_d = {1'b1, frame_q[9:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd9) busy_d = 1'b0;
         end
      end
      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            if (startReading && !empty && !busy_q && !but_rst_read) state_d = StLoad;
         end
         StLoad: begin
            pop        = 1'b1;
            rec_d      = fifo_rdata;
            byte_d     = '0;
            state_d    = StSend;
            start_byte = cts_ok && !abort;
         end
         StSend: begin
            if (!busy_d) begin
               if (abort || byte_q == 3'd6) begin
                  state_d = StIdle;
                  abort_d = 1'b0;
               end else if (cts_ok) begin
                  start_byte = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (start_byte) begin
         frame_d = {1'b1, rec_d[RecW-1 -: 8], 1'b0};
         rec_d   = {rec_d[RecW-9:0], 8'h00};
         byte_d  = byte_d + 3'd1;
         busy_d  = 1'b1;
         bit_d   = '0;
         baud_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         state_q <= StIdle;
         rec_q   <= '0;
         frame_q <= '1;
         bit_q   <= '0;
         baud_q  <= '0;
         byte_q  <= '0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rec_q   <= rec_d;
         frame_q <= frame_d;
         bit_q   <= bit_d;
         baud_q  <= baud_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         abort_q <= abort_d;
      end
   end

endmodule

// File: tb/tb_tdc_top.sv
// Testbench for tdc_top: table-driven hit pulses feed an expected-record queue, and a UART
// receiver pops and compares the records as they are transmitted.
module tb_tdc_top;

   localparam int unsigned Cpb       = 16;
   localparam int          RxTimeout = 40 * Cpb;

   logic clk_p = 1'b0, clk_n = 1'b1, irst = 1'b0;
   logic hit_p = 1'b0, hit_n = 1'b1, but_rst_read = 1'b0;
   logic startWriting = 1'b0, startReading = 1'b0, RX = 1'b1, CTS = 1'b0;
   logic led_WriteERR, led_ReadERR, TX, RTS;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] tb_cnt;
   logic [47:0] exp_q [$];
   logic [47:0] got_q [$];
   logic        exp_rts_idle;

   typedef struct {
      logic sw_rise;
      logic sw_mid;
      int   len;
      int   gap;
   } hit_vec_t;
   hit_vec_t vecs [7];
   hit_vec_t hv;

   tdc_top #(.CLKS_PER_BIT(Cpb), .CNT_W(32), .FIFO_DEPTH(16)) dut (
      .clk_p(clk_p), .clk_n(clk_n), .irst(irst), .hit_p(hit_p), .hit_n(hit_n),
      .but_rst_read(but_rst_read), .startWriting(startWriting), .startReading(startReading),
      .led_WriteERR(led_WriteERR), .led_ReadERR(led_ReadERR), .RX(RX), .TX(TX),
      .CTS(CTS), .RTS(RTS)
   );

   always #5 begin
      clk_p = ~clk_p;
      clk_n = ~clk_n;
   end

   // Reference coarse counter.
   always @(posedge clk_p or negedge irst) begin
      if (!irst) tb_cnt <= '0;
      else       tb_cnt <= tb_cnt + 32'd1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_p);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // A recorded pulse rises at tb_cnt+3 and has width len.
   task automatic do_hit(input hit_vec_t v);
      int hold;
      startWriting = v.sw_rise;
      hit_p = 1'b1;
      hit_n = 1'b0;
      if (v.sw_rise) exp_q.push_back({tb_cnt + 32'd3, 16'(v.len)});
      hold = (v.len < 5) ? v.len : 5;
      step(hold);
      startWriting = v.sw_mid;
      step(v.len - hold);
      hit_p = 1'b0;
      hit_n = 1'b1;
      step(v.gap);
   endtask

   task automatic wait_tx_low(output bit ok);
      int t;
      t = 0;
      while (TX !== 1'b0 && t < RxTimeout) begin
         step(1);
         t++;
      end
      ok = (TX === 1'b0);
   endtask

   task automatic rx_byte(output logic [9:0] frame, output bit ok);
      frame = '1;
      wait_tx_low(ok);
      if (!ok) return;
      step(Cpb / 2);
      frame[0] = TX;
      for (int i = 1; i < 10; i++) begin
         step(Cpb);
         frame[i] = TX;
      end
   endtask

   task automatic rx_record(output logic [47:0] rec, output bit ok);
      logic [9:0] fr;
      bit         bok;
      rec = '0;
      ok  = 1'b1;
      for (int b = 0; b < 6; b++) begin
         rx_byte(fr, bok);
         if (!bok) begin
            ok = 1'b0;
            return;
         end
         check("frame_stop_start", {62'd0, fr[9], fr[0]}, 64'b10);
         rec = {rec[39:0], fr[8:1]};
      end
   endtask

   task automatic read_records(input string tag);
      logic [47:0] got, exp_rec;
      bit          ok;
      int          idx;
      idx = 0;
      while (exp_q.size() > 0) begin
         exp_rec = exp_q.pop_front();
         rx_record(got, ok);
         if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no frame for record %0d, got nothing expected %h",
                     tag, idx, exp_rec);
            exp_q.delete();
            return;
         end
         check(tag, {16'd0, got}, {16'd0, exp_rec});
         got_q.push_back(got);
         idx++;
      end
   endtask

   task automatic expect_tx_idle(input string name, input int cycles);
      int lows;
      lows = 0;
      repeat (cycles) begin
         step(1);
         if (TX !== 1'b1) lows++;
      end
      check(name, lows, 0);
   endtask

   initial begin
      bit ok;
`ifdef UART_FLOW_CTRL_EN
      exp_rts_idle = 1'b1;
`else
      exp_rts_idle = 1'b0;
`endif
      vecs[0] = '{1'b1, 1'b1, 3, 118};
      vecs[1] = '{1'b1, 1'b1, 5, 10};
      vecs[2] = '{1'b0, 1'b0, 4, 6};
      vecs[3] = '{1'b1, 1'b0, 9, 6};
      vecs[4] = '{1'b0, 1'b1, 9, 6};
      vecs[5] = '{1'b1, 1'b1, 1, 5};
      vecs[6] = '{1'b1, 1'b1, 40, 5};

      step(3);
      check("rst_tx", TX, 1);
      check("rst_rts", RTS, exp_rts_idle);
      check("rst_led_w", led_WriteERR, 0);
      check("rst_led_r", led_ReadERR, 0);
      irst = 1'b1;
      step(2);

      for (int i = 0; i < 7; i++) do_hit(vecs[i]);
      startWriting = 1'b0;
      step(10);
      check("rts_noread", RTS, exp_rts_idle);
      check("tx_idle_noread", TX, 1);
      startReading = 1'b1;
      step(1);
      check("rts_read", RTS, 0);
      got_q.delete();
      read_records("rec_a");
      if (got_q.size() >= 2) check("rise_delta", got_q[1][47:16] - got_q[0][47:16], 121);
      step(4);
      check("tx_idle_after", TX, 1);
      check("rts_empty", RTS, exp_rts_idle);

      startReading = 1'b0;
      step(2);
      startReading = 1'b1;
      step(2);
      check("rd_err_set", led_ReadERR, 1);
      expect_tx_idle("empty_read_tx", 4 * Cpb);
      check("wr_err_clear_a", led_WriteERR, 0);
      but_rst_read = 1'b1;
      step(1);
      but_rst_read = 1'b0;
      step(1);
      check("rd_err_clr", led_ReadERR, 0);
      startReading = 1'b0;

`ifdef UART_FLOW_CTRL_EN
      CTS = 1'b1;
      hv  = '{1'b1, 1'b1, 4, 8};
      do_hit(hv);
      startWriting = 1'b0;
      step(6);
      startReading = 1'b1;
      expect_tx_idle("cts_hold", 20 * Cpb);
      CTS = 1'b0;
      read_records("rec_cts");
      startReading = 1'b0;
      step(2);
`endif

      // Overflow: 17 pulses with no readout; the last one must be dropped.
      irst = 1'b0;
      step(1);
      irst = 1'b1;
      step(2);
      hv = '{1'b1, 1'b1, 2, 4};
      for (int i = 0; i < 17; i++) do_hit(hv);
      void'(exp_q.pop_back());
      startWriting = 1'b0;
      step(10);
      check("ovf_led_w", led_WriteERR, 1);
      check("ovf_led_r", led_ReadERR, 0);
      but_rst_read = 1'b1;
      step(1);
      but_rst_read = 1'b0;
      step(1);
      check("ovf_led_w_clr", led_WriteERR, 0);
      startReading = 1'b1;
      read_records("rec_ovf");
      expect_tx_idle("no_17th", 15 * Cpb);
      check("ovf_rts_empty", RTS, exp_rts_idle);
      startReading = 1'b0;
      step(2);

      // Reset asserted mid-start-bit must force TX high immediately.
      hv = '{1'b1, 1'b1, 3, 6};
      do_hit(hv);
      exp_q.delete();
      startWriting = 1'b0;
      step(6);
      startReading = 1'b1;
      wait_tx_low(ok);
      check("mid_tx_start", {63'd0, ok}, 1);
      step(Cpb / 2);
      check("mid_tx_low", TX, 0);
      startReading = 1'b0;
      irst = 1'b0;
      #1;
      check("async_rst_tx", TX, 1);
      check("async_rst_rts", RTS, exp_rts_idle);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
